// File: rtl/ddr_rx.sv
// ddr_rx: HDR-DDR receive deserializer.
//   Samples SDA once per SCL edge strobe (pos or neg, coincident strobes count
//   once) and assembles the field selected by the ddr/ccc controller:
//   preamble (2 bits), data word (16 data + 2 parity), token (4), CRC5 (5).
// Ports:
//   i_sys_clk / i_sys_rst       clock, synchronous active-low reset
//   i_ddrccc_rx_en / _rx_mode   block enable and receive mode from controller
//   i_sclgen_scl_pos/neg_edge   one-cycle SCL edge strobes
//   i_sdahnd_serial_data        synchronized SDA
//   i_crc_crc_value             CRC5 from the CRC engine, compared in CRC mode
//   o_ddrccc_mode_done          one-cycle pulse, one cycle after the last bit
//   o_ddrccc_preamble           last preamble pair, first bit in MSB
//   o_ddrccc_error              sticky parity/token/CRC error for the last mode
//   o_regf_wr_en/_data_wr       received data byte to the register file
//   o_crc_en/_parallel_data     same byte to the CRC engine
module ddr_rx #(
  parameter logic [3:0] TOKEN     = 4'b1100,
  parameter int         DATA_BITS = 16
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_ddrccc_rx_en,
  input  logic [3:0] i_ddrccc_rx_mode,
  input  logic       i_sclgen_scl_pos_edge,
  input  logic       i_sclgen_scl_neg_edge,
  input  logic       i_sdahnd_serial_data,
  input  logic [4:0] i_crc_crc_value,
  output logic       o_ddrccc_mode_done,
  output logic [1:0] o_ddrccc_preamble,
  output logic       o_ddrccc_error,
  output logic       o_regf_wr_en,
  output logic [7:0] o_regf_data_wr,
  output logic       o_crc_en,
  output logic [7:0] o_crc_parallel_data
);

  localparam int WORD_BITS = DATA_BITS + 2;
  localparam logic [3:0] MODE_PREAMBLE = 4'b0000;
  localparam logic [3:0] MODE_DATA     = 4'b0001;
  localparam logic [3:0] MODE_TOKEN    = 4'b0010;
  localparam logic [3:0] MODE_CRC      = 4'b0011;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DONE} state_t;

  state_t               r_state;
  logic [3:0]           r_mode;
  logic [4:0]           r_bit_cnt;
  // The final bit of the longest field is taken straight from SDA, so the
  // register only needs to hold all but one bit.
  logic [WORD_BITS-2:0] r_shift;
  logic                 r_done;
  logic [1:0]           r_preamble;
  logic                 r_error;
  logic                 r_byte_vld;
  logic [7:0]           r_byte;

  logic                   w_sample;
  logic                   w_mode_valid;
  logic [WORD_BITS-1:0]   w_shift_next;
  logic [4:0]             w_cnt_next;
  logic [4:0]             w_target;
  logic [DATA_BITS-1:0]   w_word;
  logic [DATA_BITS/2-1:0] w_odd;
  logic [DATA_BITS/2-1:0] w_even;
  logic                   w_pa1_exp;
  logic                   w_pa0_exp;
  logic                   w_last_err;

  // Coincident strobes collapse into a single sample.
  assign w_sample     = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  assign w_mode_valid = (i_ddrccc_rx_mode[3:2] == 2'b00);
  assign w_shift_next = {r_shift, i_sdahnd_serial_data};
  assign w_cnt_next   = r_bit_cnt + 5'd1;

  // Only meaningful on the final data-word sample: data above, PA1/PA0 below.
  assign w_word = w_shift_next[WORD_BITS-1:2];

  generate
    for (genvar gi = 0; gi < DATA_BITS / 2; gi++) begin : g_par
      assign w_odd[gi]  = w_word[2*gi+1];
      assign w_even[gi] = w_word[2*gi];
    end
  endgenerate

  assign w_pa1_exp = ^w_odd;
  assign w_pa0_exp = ~(^w_even);

  always_comb begin
    w_target = 5'd0;
    case (r_mode)
      MODE_PREAMBLE: w_target = 5'd2;
      MODE_DATA:     w_target = 5'(WORD_BITS);
      MODE_TOKEN:    w_target = 5'd4;
      MODE_CRC:      w_target = 5'd5;
      default:       w_target = 5'd0;
    endcase
  end

  // Error verdict evaluated on the cycle the last bit arrives.
  always_comb begin
    w_last_err = 1'b0;
    case (r_mode)
      MODE_DATA:  w_last_err = (w_shift_next[1] != w_pa1_exp) |
                               (w_shift_next[0] != w_pa0_exp);
      MODE_TOKEN: w_last_err = (w_shift_next[3:0] != TOKEN);
      MODE_CRC:   w_last_err = (w_shift_next[4:0] != i_crc_crc_value);
      default:    w_last_err = 1'b0;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst || !i_ddrccc_rx_en) begin
      r_state    <= ST_IDLE;
      r_mode     <= 4'd0;
      r_bit_cnt  <= 5'd0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_byte_vld <= 1'b0;
      r_byte     <= 8'd0;
      // Disable keeps the last preamble; only reset clears it.
      if (!i_sys_rst) begin
        r_preamble <= 2'b00;
      end
    end else begin
      r_done     <= 1'b0;
      r_byte_vld <= 1'b0;
      case (r_state)
        // DONE shares IDLE's start logic so a sample landing in the DONE
        // cycle becomes bit 1 of the next mode.
        ST_IDLE, ST_DONE: begin
          if (w_sample && w_mode_valid) begin
            r_state   <= ST_RECV;
            r_mode    <= i_ddrccc_rx_mode;
            r_bit_cnt <= 5'd1;
            r_shift   <= {{(WORD_BITS-2){1'b0}}, i_sdahnd_serial_data};
            r_error   <= 1'b0;
          end else begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 5'd0;
            r_shift   <= '0;
          end
        end
        ST_RECV: begin
          if (i_ddrccc_rx_mode != r_mode) begin
            // Mode changed mid-field: drop it silently.
            r_state   <= ST_IDLE;
            r_bit_cnt <= 5'd0;
            r_shift   <= '0;
          end else if (w_sample) begin
            r_shift   <= w_shift_next[WORD_BITS-2:0];
            r_bit_cnt <= w_cnt_next;
            if (r_mode == MODE_DATA &&
                (w_cnt_next == 5'd8 || w_cnt_next == 5'(DATA_BITS))) begin
              r_byte_vld <= 1'b1;
              r_byte     <= w_shift_next[7:0];
            end
            if (w_cnt_next == w_target) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_error <= w_last_err;
              if (r_mode == MODE_PREAMBLE) begin
                r_preamble <= w_shift_next[1:0];
              end
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bit_cnt <= 5'd0;
        end
      endcase
    end
  end

  assign o_ddrccc_mode_done  = r_done;
  assign o_ddrccc_preamble   = r_preamble;
  assign o_ddrccc_error      = r_error;
  assign o_regf_wr_en        = r_byte_vld;
  assign o_regf_data_wr      = r_byte;
  assign o_crc_en            = r_byte_vld;
  assign o_crc_parallel_data = r_byte;

endmodule

// File: tb/tb_ddr_rx.sv
// Directed bench for ddr_rx. Inputs change on the falling clock edge and
// outputs are examined on the falling edge, half a cycle after the rising
// edge that updated them.
module tb_ddr_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] mode;
  logic       pos;
  logic       neg;
  logic       sda;
  logic [4:0] crc_val;
  logic       done;
  logic [1:0] pre;
  logic       err;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       crc_en;
  logic [7:0] crc_data;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int crc_mis = 0;
  int snap_wr;
  int snap_done;

  // D = 16'hA53C: odd-position bits 15,13,5,3 set -> PA1 = 0;
  // even-position bits 10,8,4,2 set -> PA0 = 0 ^ 1 = 1.
  localparam logic [17:0] WORD_OK  = {16'hA53C, 2'b01};
  localparam logic [17:0] WORD_BAD = {16'hA53C, 2'b00};

  always #5 clk = ~clk;

  ddr_rx dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst),
    .i_ddrccc_rx_en        (en),
    .i_ddrccc_rx_mode      (mode),
    .i_sclgen_scl_pos_edge (pos),
    .i_sclgen_scl_neg_edge (neg),
    .i_sdahnd_serial_data  (sda),
    .i_crc_crc_value       (crc_val),
    .o_ddrccc_mode_done    (done),
    .o_ddrccc_preamble     (pre),
    .o_ddrccc_error        (err),
    .o_regf_wr_en          (wr_en),
    .o_regf_data_wr        (wr_data),
    .o_crc_en              (crc_en),
    .o_crc_parallel_data   (crc_data)
  );

  // Pulse counters; read only on falling edges where no pulse is present.
  always @(negedge clk) begin
    if (wr_en) wr_cnt++;
    if (done) done_cnt++;
    if (crc_en !== wr_en || (wr_en && crc_data !== wr_data)) crc_mis++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sample: strobes up for a single rising edge.
  task automatic smp(input logic b, input logic p, input logic n);
    sda = b;
    pos = p;
    neg = n;
    @(negedge clk);
    pos = 1'b0;
    neg = 1'b0;
  endtask

  task automatic send_word(input logic [17:0] w, input logic exp_err, input string tag);
    for (int i = 0; i < 18; i++) begin
      smp(w[17-i], i[0], ~i[0]);
      if (i == 0)  chk({tag, "_errclr"}, 32'(err), 32'd0);
      if (i == 7) begin
        chk({tag, "_wr1"}, 32'(wr_en), 32'd1);
        chk({tag, "_d1"}, 32'(wr_data), 32'hA5);
        chk({tag, "_crc1"}, 32'({crc_en, crc_data}), 32'h1A5);
      end
      if (i == 8)  chk({tag, "_wr1_off"}, 32'(wr_en), 32'd0);
      if (i == 15) begin
        chk({tag, "_wr2"}, 32'(wr_en), 32'd1);
        chk({tag, "_d2"}, 32'(wr_data), 32'h3C);
        chk({tag, "_crc2"}, 32'({crc_en, crc_data}), 32'h13C);
      end
      if (i == 16) chk({tag, "_early"}, 32'(done), 32'd0);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic send_bits(input logic [4:0] v, input int n, input logic exp_err, input string tag);
    for (int i = 0; i < n; i++) begin
      smp(v[n-1-i], ~i[0], i[0]);
      if (i == 0)   chk({tag, "_errclr"}, 32'(err), 32'd0);
      if (i == n-2) chk({tag, "_early"}, 32'(done), 32'd0);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; mode = 4'd0; pos = 1'b0; neg = 1'b0;
    sda = 1'b0; crc_val = 5'b10110;
    @(negedge clk);

    // Reset held with strobes toggling.
    for (int i = 0; i < 3; i++) begin
      sda = 1'b1; pos = i[0]; neg = ~i[0];
      @(negedge clk);
    end
    pos = 1'b0; neg = 1'b0;
    chk("rst_outs", 32'({done, pre, err, wr_en, wr_data, crc_en, crc_data}), 32'd0);
    chk("rst_nodone", 32'(done_cnt), 32'd0);

    // Invalid mode: samples ignored.
    rst = 1'b1; mode = 4'hF;
    for (int i = 0; i < 4; i++) smp(1'b1, i[0], ~i[0]);
    idle(2);
    chk("inv_nodone", 32'(done_cnt), 32'd0);
    chk("inv_outs", 32'({done, pre, err, wr_en, wr_data}), 32'd0);

    // Preamble 0 then 1.
    mode = 4'b0000; idle(1);
    smp(1'b0, 1'b0, 1'b1);
    chk("pre_early", 32'(done), 32'd0);
    smp(1'b1, 1'b1, 1'b0);
    chk("pre_done", 32'(done), 32'd1);
    chk("pre_val", 32'(pre), 32'd1);
    chk("pre_err", 32'(err), 32'd0);
    idle(1);
    chk("pre_pulse1", 32'(done), 32'd0);
    chk("pre_hold", 32'(pre), 32'd1);

    // Data words: good parity, then PA0 flipped.
    mode = 4'b0001; idle(1);
    send_word(WORD_OK, 1'b0, "w1");
    idle(1);
    chk("w1_pulse1", 32'(done), 32'd0);
    send_word(WORD_BAD, 1'b1, "w2");
    idle(1);

    // Token then CRC, each pair back-to-back (2nd field starts in DONE cycle).
    mode = 4'b0010; idle(1);
    chk("err_sticky", 32'(err), 32'd1);
    snap_done = done_cnt;
    send_bits(5'b01100, 4, 1'b0, "tok_ok");
    send_bits(5'b01101, 4, 1'b1, "tok_bad");
    mode = 4'b0011; idle(1);
    send_bits(5'b10110, 5, 1'b0, "crc_ok");
    send_bits(5'b10111, 5, 1'b1, "crc_bad");
    idle(1);
    chk("b2b_done_cnt", 32'(done_cnt - snap_done), 32'd4);

    // Disable clears error but keeps preamble.
    en = 1'b0; idle(2);
    chk("dis_err", 32'(err), 32'd0);
    chk("dis_pre", 32'(pre), 32'd1);
    en = 1'b1;

    // Coincident strobes count once.
    mode = 4'b0010; idle(1);
    smp(1'b1, 1'b1, 1'b1);
    smp(1'b1, 1'b1, 1'b0);
    smp(1'b0, 1'b0, 1'b1);
    chk("sim_early", 32'(done), 32'd0);
    smp(1'b0, 1'b1, 1'b1);
    chk("sim_done", 32'(done), 32'd1);
    chk("sim_err", 32'(err), 32'd0);
    idle(1);

    // Mode change after 5 data bits aborts.
    mode = 4'b0001; idle(1);
    snap_wr = wr_cnt; snap_done = done_cnt;
    for (int i = 0; i < 5; i++) smp(WORD_OK[17-i], i[0], ~i[0]);
    mode = 4'b0010; idle(3);
    chk("abm_nowr", 32'(wr_cnt - snap_wr), 32'd0);
    chk("abm_nodone", 32'(done_cnt - snap_done), 32'd0);
    send_bits(5'b01100, 4, 1'b0, "abm_tok");
    idle(1);

    // Reset after 10 data bits aborts (first byte already went out at bit 8).
    mode = 4'b0001; idle(1);
    snap_done = done_cnt;
    for (int i = 0; i < 10; i++) smp(WORD_OK[17-i], i[0], ~i[0]);
    snap_wr = wr_cnt;
    rst = 1'b0; idle(2);
    rst = 1'b1; idle(1);
    chk("abr_nowr", 32'(wr_cnt - snap_wr), 32'd0);
    chk("abr_nodone", 32'(done_cnt - snap_done), 32'd0);
    chk("abr_outs", 32'({done, pre, err, wr_en, wr_data, crc_en, crc_data}), 32'd0);
    send_word(WORD_OK, 1'b0, "w3");
    idle(2);
    chk("crc_mirror", 32'(crc_mis), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
